acc_stack: RTL and testbench
============================

Name: acc_stack

Overview:
- Clocked, parametrised accumulator for the EnDMe datapath.
- Selects one of four sources (immediate, register file, memory, ALU) into the accumulator register.
- Adds a LIFO save stack of DEPTH entries with push, pop and swap operations, so subroutine code can save and restore the accumulator.
- Provides zero/negative status and sticky overflow/underflow error flags to the control unit.

Parameters:
- WIDTH, 8, accumulator and data-path width in bits.
- DEPTH, 4, number of save-stack entries. Must be at least 2.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_imm_in  input  WIDTH  immediate source.
- data_reg_in  input  WIDTH  register-file source.
- data_mem_in  input  WIDTH  memory read-data source.
- data_alu_in  input  WIDTH  ALU result source.
- data_ctrl  input  2  source select: 00 imm, 01 reg, 10 mem, 11 alu.
- write_ctrl  input  1  load the selected source into the accumulator this cycle.
- op_ctrl  input  2  stack op: 00 none, 01 push, 10 pop, 11 swap.
- err_clr  input  1  clears err_ovf and err_unf.
- acc_out  output  WIDTH  accumulator register value.
- acc_zero  output  1  acc_out equals 0; combinational from acc_out.
- acc_neg  output  1  acc_out[WIDTH-1]; combinational.
- depth_out  output  $clog2(DEPTH+1)  number of valid stack entries.
- stack_full  output  1  depth_out equals DEPTH.
- stack_empty  output  1  depth_out equals 0.
- err_ovf  output  1  sticky: a push was attempted while the stack was full.
- err_unf  output  1  sticky: a pop or swap was attempted while the stack was empty.

Behaviour:
- Reset (asynchronous, takes effect immediately while high):
  - acc_out, depth_out, err_ovf and err_unf all go to 0.
  - Therefore stack_empty=1, stack_full=0, acc_zero=1, acc_neg=0.
  - Stack storage is not reset; its contents are don't-care until pushed.
- Write: on a rising clk edge with write_ctrl=1 and no accumulator-overriding op, acc_out takes the source selected by data_ctrl. Latency is 1 cycle.
- With write_ctrl=0 and op none, acc_out holds its value.
- Push (op 01), stack not full:
  - stack[depth] gets the pre-edge acc_out; depth increments.
  - write_ctrl is still honoured in the same cycle, so the old value is saved and the new value is loaded.
- Pop (op 10), stack not empty:
  - acc_out gets stack[depth-1]; depth decrements.
  - write_ctrl is ignored that cycle (pop has priority).
- Swap (op 11), stack not empty:
  - acc_out gets stack[depth-1], and stack[depth-1] gets the pre-edge acc_out; depth is unchanged.
  - write_ctrl is ignored that cycle.
- Failed op:
  - Push while full: err_ovf is set; stack and depth are unchanged.
  - Pop or swap while empty: err_unf is set; acc_out is unchanged by the op.
  - In both cases write_ctrl is honoured as if op were none.
- Error flags stay set until err_clr=1 at a clock edge or reset.
- If err_clr and a new error occur in the same cycle, the set wins (flag reads 1 afterwards).
- Depth wraps never occur; depth is saturated by the full/empty checks above.
- Status outputs: acc_zero, acc_neg, stack_full and stack_empty are purely combinational from registered state; there are no extra cycles of latency.
- Reset asserted in the middle of a sequence discards all pushed entries (depth returns to 0). A subsequent pop flags err_unf.

Test Plan:
- Reset, then data_ctrl=01 with data_reg_in=0x02 and write_ctrl=1 for one edge -> acc_out=0x02, acc_zero=0.
- Load 0x11, then push with write of data_alu_in=0x44 in the same cycle -> acc_out=0x44, depth_out=1. Then pop -> acc_out=0x11, depth_out=0, stack_empty=1.
- Push 0xA1, 0xB2, 0xC3, 0xD4 with DEPTH=4 -> stack_full=1. A fifth push with acc_out=0xE5 -> err_ovf=1, depth_out=4. Four pops then return 0xD4, 0xC3, 0xB2, 0xA1 in that order.
- Pop on an empty stack with write_ctrl=1, data_imm_in=0x07 -> err_unf=1, acc_out=0x07. Then err_clr for one edge -> err_unf=0.
- acc_out=0x80, push, load 0x05, swap -> acc_out=0x80, acc_neg=1, depth_out=1, and a following pop yields 0x05.
- Push twice, then assert reset asynchronously between clock edges -> acc_out=0 and depth_out=0 immediately, before the next edge.

Source files
------------

// File: rtl/acc_stack.sv
// Accumulator register with four-way source select and a LIFO save stack
// (push / pop / swap) plus zero/negative status and sticky error flags.
module acc_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4   // must be at least 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           data_imm_in,
  input  logic [WIDTH-1:0]           data_reg_in,
  input  logic [WIDTH-1:0]           data_mem_in,
  input  logic [WIDTH-1:0]           data_alu_in,
  input  logic [1:0]                 data_ctrl,
  input  logic                       write_ctrl,
  input  logic [1:0]                 op_ctrl,
  input  logic                       err_clr,
  output logic [WIDTH-1:0]           acc_out,
  output logic                       acc_zero,
  output logic                       acc_neg,
  output logic [$clog2(DEPTH+1)-1:0] depth_out,
  output logic                       stack_full,
  output logic                       stack_empty,
  output logic                       err_ovf,
  output logic                       err_unf
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);

  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;
  localparam logic [1:0] OP_SWAP = 2'b11;

  logic [WIDTH-1:0] acc_reg, acc_next;
  logic [DW-1:0]    depth_reg, depth_next;
  logic             ovf_reg, ovf_next;
  logic             unf_reg, unf_next;
  logic [WIDTH-1:0] src_sel;
  logic [WIDTH-1:0] stack_mem [DEPTH];

  logic          full, empty;
  logic          push_ok, pop_ok, swap_ok;
  logic          ovf_evt, unf_evt;
  logic [IW-1:0] push_idx, top_idx;

  assign full     = (depth_reg == DEPTH_MAX);
  assign empty    = (depth_reg == '0);
  assign push_idx = depth_reg[IW-1:0];
  assign top_idx  = IW'(depth_reg - DW'(1));

  assign push_ok = (op_ctrl == OP_PUSH) && !full;
  assign pop_ok  = (op_ctrl == OP_POP)  && !empty;
  assign swap_ok = (op_ctrl == OP_SWAP) && !empty;
  assign ovf_evt = (op_ctrl == OP_PUSH) && full;
  assign unf_evt = ((op_ctrl == OP_POP) || (op_ctrl == OP_SWAP)) && empty;

  always_comb begin
    src_sel = data_imm_in;
    case (data_ctrl)
      2'b00:   src_sel = data_imm_in;
      2'b01:   src_sel = data_reg_in;
      2'b10:   src_sel = data_mem_in;
      default: src_sel = data_alu_in;
    endcase
  end

  // Pop and swap override the write; a push or a failed op leaves write_ctrl in effect.
  always_comb begin
    acc_next   = acc_reg;
    depth_next = depth_reg;
    if (pop_ok || swap_ok) begin
      acc_next = stack_mem[top_idx];
    end else if (write_ctrl) begin
      acc_next = src_sel;
    end
    if (push_ok) begin
      depth_next = depth_reg + DW'(1);
    end else if (pop_ok) begin
      depth_next = depth_reg - DW'(1);
    end
  end

  // Setting an error wins over clearing it in the same cycle.
  always_comb begin
    ovf_next = ovf_reg;
    unf_next = unf_reg;
    if (err_clr) begin
      ovf_next = 1'b0;
      unf_next = 1'b0;
    end
    if (ovf_evt) ovf_next = 1'b1;
    if (unf_evt) unf_next = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_reg   <= '0;
      depth_reg <= '0;
      ovf_reg   <= 1'b0;
      unf_reg   <= 1'b0;
    end else begin
      acc_reg   <= acc_next;
      depth_reg <= depth_next;
      ovf_reg   <= ovf_next;
      unf_reg   <= unf_next;
    end
  end

  // Stack contents are deliberately not reset; depth alone defines validity.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      stack_mem[push_idx] <= acc_reg;
    end else if (swap_ok) begin
      stack_mem[top_idx] <= acc_reg;
    end
  end

  assign acc_out     = acc_reg;
  assign acc_zero    = (acc_reg == '0);
  assign acc_neg     = acc_reg[WIDTH-1];
  assign depth_out   = depth_reg;
  assign stack_full  = full;
  assign stack_empty = empty;
  assign err_ovf     = ovf_reg;
  assign err_unf     = unf_reg;

endmodule

// File: tb/tb_acc_stack.sv
// Table-driven bench for acc_stack: directed vectors with hand-computed results,
// plus hand-written reset and asynchronous-reset sequences.
module tb_acc_stack;

  logic       clk;
  logic       reset;
  logic [7:0] data_imm_in, data_reg_in, data_mem_in, data_alu_in;
  logic [1:0] data_ctrl;
  logic       write_ctrl;
  logic [1:0] op_ctrl;
  logic       err_clr;
  logic [7:0] acc_out;
  logic       acc_zero, acc_neg;
  logic [2:0] depth_out;
  logic       stack_full, stack_empty, err_ovf, err_unf;

  int n_cmp  = 0;
  int n_fail = 0;

  acc_stack #(.WIDTH(8), .DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .data_imm_in (data_imm_in),
    .data_reg_in (data_reg_in),
    .data_mem_in (data_mem_in),
    .data_alu_in (data_alu_in),
    .data_ctrl   (data_ctrl),
    .write_ctrl  (write_ctrl),
    .op_ctrl     (op_ctrl),
    .err_clr     (err_clr),
    .acc_out     (acc_out),
    .acc_zero    (acc_zero),
    .acc_neg     (acc_neg),
    .depth_out   (depth_out),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .err_ovf     (err_ovf),
    .err_unf     (err_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [1:0] dc;
    logic       wr;
    logic [1:0] op;
    logic       clr;
    logic [7:0] val;
    logic [7:0] acc;
    logic [2:0] depth;
    logic       ovf;
    logic       unf;
  } vec_t;

  localparam int NVEC = 27;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic [1:0] dc, input logic wr, input logic [1:0] op,
                              input logic clr, input logic [7:0] val, input logic [7:0] acc,
                              input logic [2:0] depth, input logic ovf, input logic unf);
    vec_t v;
    v.dc = dc; v.wr = wr; v.op = op; v.clr = clr; v.val = val;
    v.acc = acc; v.depth = depth; v.ovf = ovf; v.unf = unf;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got 0x%02h, required 0x%02h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input int idx, input logic [7:0] acc, input logic [2:0] depth,
                           input logic ovf, input logic unf);
    check("acc_out",     idx, acc_out,            acc);
    check("depth_out",   idx, {5'd0, depth_out},  {5'd0, depth});
    check("err_ovf",     idx, {7'd0, err_ovf},    {7'd0, ovf});
    check("err_unf",     idx, {7'd0, err_unf},    {7'd0, unf});
    check("stack_full",  idx, {7'd0, stack_full}, {7'd0, (depth == 3'd4)});
    check("stack_empty", idx, {7'd0, stack_empty},{7'd0, (depth == 3'd0)});
    check("acc_zero",    idx, {7'd0, acc_zero},   {7'd0, (acc == 8'h00)});
    check("acc_neg",     idx, {7'd0, acc_neg},    {7'd0, acc[7]});
  endtask

  // The selected source carries val; the others carry distinct decoys.
  task automatic drive(input logic [1:0] dc, input logic wr, input logic [1:0] op,
                       input logic clr, input logic [7:0] val);
    data_ctrl   = dc;
    write_ctrl  = wr;
    op_ctrl     = op;
    err_clr     = clr;
    data_imm_in = (dc == 2'b00) ? val : (val ^ 8'h5A);
    data_reg_in = (dc == 2'b01) ? val : (val ^ 8'hA5);
    data_mem_in = (dc == 2'b10) ? val : (val ^ 8'h3C);
    data_alu_in = (dc == 2'b11) ? val : (val ^ 8'hC3);
  endtask

  task automatic step(input int idx, input vec_t v);
    @(negedge clk);
    drive(v.dc, v.wr, v.op, v.clr, v.val);
    @(posedge clk);
    #1;
    $display("txn %0d: dc=%0d wr=%0d op=%0d clr=%0d val=%02h -> acc=%02h depth=%0d ovf=%0d unf=%0d",
             idx, v.dc, v.wr, v.op, v.clr, v.val, acc_out, depth_out, err_ovf, err_unf);
    check_all(idx, v.acc, v.depth, v.ovf, v.unf);
  endtask

  initial begin
    //            dc    wr  op    clr  val    acc    d  ovf unf
    vecs[0]  = mk(2'd1, 1, 2'd0, 0, 8'h02, 8'h02, 0, 0, 0);
    vecs[1]  = mk(2'd0, 1, 2'd0, 0, 8'h11, 8'h11, 0, 0, 0);
    vecs[2]  = mk(2'd3, 1, 2'd1, 0, 8'h44, 8'h44, 1, 0, 0);  // push + write
    vecs[3]  = mk(2'd0, 1, 2'd2, 0, 8'h99, 8'h11, 0, 0, 0);  // pop beats write
    vecs[4]  = mk(2'd0, 1, 2'd0, 0, 8'hA1, 8'hA1, 0, 0, 0);
    vecs[5]  = mk(2'd2, 1, 2'd1, 0, 8'hB2, 8'hB2, 1, 0, 0);
    vecs[6]  = mk(2'd1, 1, 2'd1, 0, 8'hC3, 8'hC3, 2, 0, 0);
    vecs[7]  = mk(2'd3, 1, 2'd1, 0, 8'hD4, 8'hD4, 3, 0, 0);
    vecs[8]  = mk(2'd0, 1, 2'd1, 0, 8'hE5, 8'hE5, 4, 0, 0);
    vecs[9]  = mk(2'd0, 0, 2'd1, 0, 8'h66, 8'hE5, 4, 1, 0);  // push while full
    vecs[10] = mk(2'd0, 0, 2'd2, 0, 8'h00, 8'hD4, 3, 1, 0);
    vecs[11] = mk(2'd0, 0, 2'd2, 0, 8'h00, 8'hC3, 2, 1, 0);
    vecs[12] = mk(2'd0, 0, 2'd2, 0, 8'h00, 8'hB2, 1, 1, 0);
    vecs[13] = mk(2'd0, 0, 2'd2, 0, 8'h00, 8'hA1, 0, 1, 0);
    vecs[14] = mk(2'd0, 0, 2'd0, 1, 8'h00, 8'hA1, 0, 0, 0);
    vecs[15] = mk(2'd0, 1, 2'd2, 0, 8'h07, 8'h07, 0, 0, 1);  // pop empty, write honoured
    vecs[16] = mk(2'd1, 1, 2'd3, 0, 8'h08, 8'h08, 0, 0, 1);  // swap empty
    vecs[17] = mk(2'd0, 0, 2'd0, 1, 8'h00, 8'h08, 0, 0, 0);
    vecs[18] = mk(2'd3, 1, 2'd0, 0, 8'h80, 8'h80, 0, 0, 0);
    vecs[19] = mk(2'd0, 0, 2'd1, 0, 8'h00, 8'h80, 1, 0, 0);
    vecs[20] = mk(2'd2, 1, 2'd0, 0, 8'h05, 8'h05, 1, 0, 0);
    vecs[21] = mk(2'd0, 1, 2'd3, 0, 8'h33, 8'h80, 1, 0, 0);  // swap beats write
    vecs[22] = mk(2'd0, 0, 2'd2, 0, 8'h00, 8'h05, 0, 0, 0);
    vecs[23] = mk(2'd0, 0, 2'd2, 1, 8'h00, 8'h05, 0, 0, 1);  // set wins over clear
    vecs[24] = mk(2'd0, 1, 2'd0, 0, 8'h00, 8'h00, 0, 0, 1);
    vecs[25] = mk(2'd0, 0, 2'd0, 0, 8'h77, 8'h00, 0, 0, 1);  // hold
    vecs[26] = mk(2'd0, 0, 2'd0, 1, 8'h00, 8'h00, 0, 0, 0);

    reset = 1'b1;
    drive(2'd0, 0, 2'd0, 0, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    check_all(-1, 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      step(i, vecs[i]);
    end

    // Underflow, two pushes, then reset asserted between edges.
    step(100, mk(2'd0, 0, 2'd2, 0, 8'h00, 8'h00, 0, 0, 1));
    step(101, mk(2'd2, 1, 2'd0, 0, 8'h3C, 8'h3C, 0, 0, 1));
    step(102, mk(2'd2, 1, 2'd1, 0, 8'h4B, 8'h4B, 1, 0, 1));
    step(103, mk(2'd0, 0, 2'd1, 0, 8'h00, 8'h4B, 2, 0, 1));
    @(negedge clk);
    drive(2'd0, 0, 2'd0, 0, 8'h00);
    #2;
    reset = 1'b1;
    #1;
    $display("txn 104: async reset -> acc=%02h depth=%0d ovf=%0d unf=%0d",
             acc_out, depth_out, err_ovf, err_unf);
    check_all(104, 8'h00, 3'd0, 1'b0, 1'b0);
    #1;
    reset = 1'b0;
    step(105, mk(2'd0, 0, 2'd2, 0, 8'h00, 8'h00, 0, 0, 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
